debug_dump_tx: RTL and testbench
================================

Name: debug_dump_tx

Overview:
- Transmit-side counterpart of the UART command/load path of the MIPS debug unit.
- On request, captures the wide MIPS debug frame (registers, memory, latches, PC) and serializes it into bytes for the UART transmitter.
- Issues one byte at a time with an `o_tx_start` pulse, then waits for `i_tx_done` before issuing the next byte.
- Sits between the MIPS debug-state vector and the UART TX core inside `Top_level`.

Parameters:
- `DATA_W`, 2554: width of the debug frame in bits.
- `BYTE_W`, 8: UART byte width.
- `NBYTES`, derived = ceil(DATA_W/BYTE_W), 320 at default: bytes per frame. Not overridable.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  request a dump; sampled only in IDLE.
- `i_frame`  in  DATA_W  debug frame; sampled on the cycle `i_start` is accepted.
- `i_tx_done`  in  1  UART TX finished the current byte (1-cycle pulse).
- `o_data_send`  out  BYTE_W  byte to transmit.
- `o_tx_start`  out  1  1-cycle pulse: UART TX loads `o_data_send`.
- `o_busy`  out  1  high from acceptance of `i_start` until the done cycle.
- `o_done`  out  1  1-cycle pulse after the last byte's `i_tx_done`.

Behaviour:
- Reset (async, `rst`=1):
  - state=IDLE, byte counter=0, shadow register=0.
  - All outputs 0: `o_data_send`=0, `o_tx_start`=0, `o_busy`=0, `o_done`=0.
- All outputs are registered.
- Frame capture:
  - Shadow register is NBYTES*BYTE_W bits wide. It is loaded with `i_frame` zero-extended in the MSBs, so pad bits are 0.
  - Byte order is LSB-first: byte 0 = `i_frame[7:0]`; the last byte holds the MSBs plus padding.
  - The shadow register shifts right by BYTE_W after each byte. No wide mux is used.
- State machine, states IDLE, SEND, WAIT, DONE:
  - IDLE: if `i_start`=1, capture the frame, counter=0, `o_busy`<=1, go to SEND.
  - SEND (one cycle): `o_data_send`<=shadow[7:0], `o_tx_start`<=1, go to WAIT.
  - WAIT: `o_tx_start`=0. On `i_tx_done`=1:
    - if counter==NBYTES-1, go to DONE;
    - else shift the shadow register, increment the counter, go to SEND.
  - DONE (one cycle): `o_done`=1, `o_busy`=0, go to IDLE. A new `i_start` is accepted from the next cycle.
- Timing:
  - `i_start` sampled at edge k: `o_tx_start`=1 and `o_data_send`=byte0 during cycle k+1.
  - `i_tx_done` sampled at edge m: next byte's `o_tx_start`=1 in cycle m+1, or `o_done`=1 in cycle m+1 for the last byte.
- `o_data_send` is held stable from its `o_tx_start` cycle until the next SEND. After DONE it keeps the last byte.
- Ignored inputs:
  - `i_start` outside IDLE, including during DONE.
  - `i_tx_done` in IDLE, SEND or DONE.
  - Changes to `i_frame` after capture.
- Counter: $clog2(NBYTES) bits, never exceeds NBYTES-1. There is no wrap-around path.
- Reset mid-transfer: immediate return to reset values; the partial dump is abandoned with no `o_done`.
- Simultaneous `i_start` and `i_tx_done` in IDLE: `i_start` wins and `i_tx_done` is ignored.

Decomposition:
- Shared debug package holds:
  - `DEBUG_FRAME_W`=2554 and `UART_BYTE_W`=8;
  - the state encoding constants IDLE=2'd0, SEND=2'd1, WAIT=2'd2, DONE=2'd3.
- Single module; no sub-module. The shift register and counter are inline.

Test Plan:
- Reset: `rst`=1 mid-idle, then `rst`=0 → all outputs 0, no `o_tx_start` for 50 cycles with `i_start`=0.
- `DATA_W`=20, `i_frame`=20'hABCDE, `i_start` pulse, `i_tx_done` 10 cycles after each `o_tx_start`:
  - bytes 8'hDE, 8'hBC, 8'h0A in that order, exactly 3 `o_tx_start` pulses;
  - `o_done` 1 cycle after the third `i_tx_done`; `o_busy` low in the same cycle.
- Default `DATA_W`=2554 with a random frame: 320 bytes, byte 319 = {6'b0, frame[2553:2552]}; reassembled bytes equal the frame.
- Spurious inputs:
  - `i_start` pulsed during WAIT and DONE → ignored, the byte stream is unchanged;
  - `i_tx_done` during IDLE → no `o_tx_start`.
- `rst` asserted after byte 2's `o_tx_start` → outputs 0 immediately, no `o_done`. A new `i_start` restarts from byte 0.
- `i_frame` changed every cycle after `i_start` → transmitted bytes match the value captured at the `i_start` edge.

Source files
------------

// File: rtl/debug_dump_tx_pkg.sv
// Shared constants and state encoding for the MIPS debug dump transmit path.
package debug_dump_tx_pkg;

    localparam int DEBUG_FRAME_W = 2554;
    localparam int UART_BYTE_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dbg_state_t;

endpackage

// File: rtl/debug_dump_tx.sv
// Captures the wide MIPS debug frame and feeds it LSB-first, one byte per
// tx_start/tx_done handshake, to the UART transmitter.
module debug_dump_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int DATA_W = DEBUG_FRAME_W,
    parameter int BYTE_W = UART_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_frame,
    input  logic              i_tx_done,
    output logic [BYTE_W-1:0] o_data_send,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_done
);

    localparam int NBYTES = (DATA_W + BYTE_W - 1) / BYTE_W;
    localparam int SHW    = NBYTES * BYTE_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    dbg_state_t        state, state_nxt;
    logic [SHW-1:0]    shadow, shadow_nxt;
    logic [SHW-1:0]    frame_ext;
    logic [SHW-1:0]    shifted;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BYTE_W-1:0] data_nxt;
    logic              tx_nxt, busy_nxt, done_nxt;

    assign frame_ext = SHW'(i_frame);
    assign shifted   = shadow >> BYTE_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            cnt         <= '0;
            o_data_send <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            cnt         <= cnt_nxt;
            o_data_send <= data_nxt;
            o_tx_start  <= tx_nxt;
            o_busy      <= busy_nxt;
            o_done      <= done_nxt;
        end
    end

    // Outputs are registered on the transition into SEND/DONE so that the
    // tx_start pulse and done pulse are visible in the cycle after the trigger.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        cnt_nxt    = cnt;
        data_nxt   = o_data_send;
        tx_nxt     = 1'b0;
        busy_nxt   = o_busy;
        done_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    shadow_nxt = frame_ext;
                    cnt_nxt    = '0;
                    data_nxt   = frame_ext[BYTE_W-1:0];
                    tx_nxt     = 1'b1;
                    busy_nxt   = 1'b1;
                    state_nxt  = SEND;
                end
            end
            SEND: state_nxt = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    if (cnt == LAST) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = DONE;
                    end else begin
                        shadow_nxt = shifted;
                        cnt_nxt    = cnt + 1'b1;
                        data_nxt   = shifted[BYTE_W-1:0];
                        tx_nxt     = 1'b1;
                        state_nxt  = SEND;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed bench for debug_dump_tx: a 20-bit instance for handshake/timing
// cases and a default-width instance for the full 320-byte frame.
module tb_debug_dump_tx;

    logic clk;
    logic rst;

    logic        s_start, s_txd;
    logic [19:0] s_frame;
    logic [7:0]  s_data;
    logic        s_txs, s_busy, s_done;

    logic          b_start, b_txd;
    logic [2553:0] b_frame;
    logic [7:0]    b_data;
    logic          b_txs, b_busy, b_done;

    int n_vec = 0;
    int n_err = 0;

    debug_dump_tx #(.DATA_W(20), .BYTE_W(8)) dut_small (
        .clk(clk), .rst(rst), .i_start(s_start), .i_frame(s_frame),
        .i_tx_done(s_txd), .o_data_send(s_data), .o_tx_start(s_txs),
        .o_busy(s_busy), .o_done(s_done)
    );

    debug_dump_tx dut_big (
        .clk(clk), .rst(rst), .i_start(b_start), .i_frame(b_frame),
        .i_tx_done(b_txd), .o_data_send(b_data), .o_tx_start(b_txs),
        .o_busy(b_busy), .o_done(b_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits nine cycles (optionally disturbing inputs), then pulses tx_done.
    task automatic s_ack(input bit perturb, output int extra);
        extra = 0;
        for (int j = 0; j < 9; j++) begin
            if (perturb) begin
                s_frame = 20'($urandom);
                s_start = (j == 4);
            end
            @(negedge clk);
            if (s_txs) extra++;
        end
        s_start = 1'b0;
        s_txd   = 1'b1;
        @(negedge clk);
        s_txd   = 1'b0;
    endtask

    task automatic run_small(input logic [19:0] f, input bit perturb, input string tag);
        logic [7:0] eb [3];
        int extra, total_extra, late_txs;
        eb[0] = f[7:0];
        eb[1] = f[15:8];
        eb[2] = {4'b0, f[19:16]};
        total_extra = 0;
        @(negedge clk);
        s_frame = f;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_txs"}, 32'(s_txs), 32'd1);
            check({tag, "_byte"}, 32'(s_data), 32'(eb[i]));
            check({tag, "_busy"}, 32'(s_busy), 32'd1);
            s_ack(perturb, extra);
            total_extra += extra;
        end
        check({tag, "_done"}, 32'(s_done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(s_busy), 32'd0);
        check({tag, "_txs_at_done"}, 32'(s_txs), 32'd0);
        check({tag, "_extra_txs"}, 32'(total_extra), 32'd0);
        if (perturb) s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check({tag, "_done_pulse"}, 32'(s_done), 32'd0);
        check({tag, "_byte_hold"}, 32'(s_data), 32'(eb[2]));
        late_txs = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (s_txs) late_txs++;
        end
        check({tag, "_no_restart"}, 32'(late_txs), 32'd0);
    endtask

    initial begin
        logic [2559:0] tmp;
        logic [2559:0] b_ext;
        int n_txs, got_bytes, n_done, extra;
        logic [7:0] last_byte;

        rst = 1'b1;
        s_start = 1'b0; s_txd = 1'b0; s_frame = '0;
        b_start = 1'b0; b_txd = 1'b0; b_frame = '0;
        repeat (3) @(negedge clk);
        check("rst_small_outs", {22'd0, s_data, s_txs, s_busy}, 32'd0);
        check("rst_big_outs", {22'd0, b_data, b_txs, b_busy, b_done}, 32'd0);
        rst = 1'b0;

        // Reset mid-idle, then 50 quiet cycles with a spurious tx_done.
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_idle_outs", {23'd0, s_data, s_txs, s_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_txs = 0;
        for (int c = 0; c < 50; c++) begin
            s_txd = (c == 10);
            b_txd = (c == 10);
            @(negedge clk);
            if (s_txs || b_txs || s_done || b_done) n_txs++;
        end
        s_txd = 1'b0;
        b_txd = 1'b0;
        check("idle_quiet", 32'(n_txs), 32'd0);

        run_small(20'hABCDE, 1'b0, "abcde");
        run_small(20'h5A3C7, 1'b1, "perturb");

        // Reset after byte 2's tx_start abandons the dump.
        @(negedge clk);
        s_frame = 20'h12345;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_ack(1'b0, extra);
        s_ack(1'b0, extra);
        check("mid_byte2_txs", 32'(s_txs), 32'd1);
        check("mid_byte2_val", 32'(s_data), 32'h01);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {22'd0, s_data, s_txs, s_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            s_txd = (c == 3);
            @(negedge clk);
            if (s_done || s_txs) n_done++;
        end
        s_txd = 1'b0;
        check("mid_rst_no_done", 32'(n_done), 32'd0);
        run_small(20'h12345, 1'b0, "restart");

        // Full-width frame, 320 bytes LSB-first.
        for (int i = 0; i < 80; i++) tmp[i*32 +: 32] = $urandom;
        b_frame = tmp[2553:0];
        b_ext = {6'b0, b_frame};
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        got_bytes = 0;
        last_byte = '0;
        for (int i = 0; i < 320; i++) begin
            for (int w = 0; w < 10 && !b_txs; w++) @(negedge clk);
            if (!b_txs) begin
                check("big_txs_timeout", 32'd0, 32'd1);
                break;
            end
            check("big_byte", 32'(b_data), 32'(b_ext[i*8 +: 8]));
            got_bytes++;
            last_byte = b_data;
            b_frame = ~b_frame;
            @(negedge clk);
            b_txd = 1'b1;
            @(negedge clk);
            b_txd = 1'b0;
        end
        check("big_count", 32'(got_bytes), 32'd320);
        check("big_byte319", 32'(last_byte), {24'd0, 6'b0, tmp[2553:2552]});
        check("big_done", 32'(b_done), 32'd1);
        check("big_busy_low", 32'(b_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
